// File: rtl/fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO push arbiter:
//   arb_state_e - arbiter ownership state (no owner / owner held)
//   mod_inc()   - increment with wrap to zero at a given modulus, used for
//                 advancing the round-robin pointer past the last owner
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Returns (value + 1) mod modulus, assuming value < modulus.
    function automatic int unsigned mod_inc(input int unsigned value,
                                            input int unsigned modulus);
        return ((value + 1) >= modulus) ? 0 : (value + 1);
    endfunction

endpackage : fifo_arb_pkg

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. Finds the first asserted valid at or
// after ptr_i, searching upward and wrapping to 0.
// Ports:
//   valid_i [NUM_REQ]  per-requester valid
//   ptr_i   [IDX_W]    search start index (must be < NUM_REQ)
//   idx_o   [IDX_W]    winner index; equals ptr_i when nothing is valid
//   any_o              at least one valid is asserted
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    localparam int unsigned NR = NUM_REQ;

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        idx_o    = ptr_i;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // Walk the NUM_REQ candidates starting at ptr_i. Since ptr_i < NUM_REQ,
        // one conditional subtract is enough to wrap, avoiding a divider.
        for (int unsigned i = 0; i < NR; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= NR) begin
                cand = cand - NR;
            end
            cand_idx = IDX_W'(cand);
            if (!any_o && valid_i[cand_idx]) begin
                idx_o = cand_idx;
                any_o = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/fifo_push_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_push_arbiter
// Arbitrates NUM_REQ push requesters onto a single FIFO push port. In IDLE the
// winner is chosen round-robin from rr_ptr; once a winner transfers it owns
// the port for up to MAX_BURST consecutive beats (LOCKED). The datapath is
// purely combinational: the FIFO sees the winner's valid/data the same cycle.
//
// Handshake: a beat transfers on a rising clk edge where fifo_push_valid_o
// and fifo_push_grant_i are both high. A requester sees req_grant_o[i] high
// in exactly that cycle. While valid is high and the FIFO withholds grant,
// the requester must hold its payload stable; the arbiter holds all state.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   req_valid_i [N]      per-requester push valid
//   req_data_i  [N*PW]   packed payloads, requester i at slice i (PW=DW+1)
//   req_grant_o [N]      per-requester grant, one-hot or zero
//   fifo_push_valid_o    push valid to FIFO
//   fifo_push_data_o     push data to FIFO
//   fifo_push_grant_i    FIFO can accept this cycle
//   owner_o              current winner index (rr_ptr when idle and no valid)
//   locked_o             high while ownership is held (exposes FSM state)
// ----------------------------------------------------------------------------
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_data_i,
    output logic [NUM_REQ-1:0]                req_grant_o,
    output logic                              fifo_push_valid_o,
    output logic [DATA_WIDTH:0]               fifo_push_data_o,
    input  logic                              fifo_push_grant_i,
    output logic [$clog2(NUM_REQ)-1:0]        owner_o,
    output logic                              locked_o
);

    localparam int PW    = DATA_WIDTH + 1;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [CNT_W-1:0] BEAT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [IDX_W-1:0] winner;
    logic             win_valid;
    logic             push_xfer;
    logic [CNT_W-1:0] beat_inc;

    logic [PW-1:0]    slice_w [NUM_REQ];

    // ------------------------------------------------------------------
    // Payload slices as an array so the winner can index them directly.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign slice_w[gi] = req_data_i[gi*PW +: PW];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid_i (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // ------------------------------------------------------------------
    // Winner selection and combinational push path. While rst_n is low the
    // outputs are forced quiet even if requesters drive valid, so the FIFO
    // never sees a push during reset.
    // ------------------------------------------------------------------
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        if (rst_n) begin
            if (state_q == ARB_LOCKED) begin
                winner    = owner_q;
                win_valid = req_valid_i[owner_q];
            end else begin
                winner    = pick_idx;
                win_valid = pick_any;
            end
        end
    end

    assign push_xfer         = win_valid && fifo_push_grant_i;
    assign fifo_push_valid_o = win_valid;
    assign fifo_push_data_o  = slice_w[winner];
    assign owner_o           = winner;
    assign locked_o          = (state_q == ARB_LOCKED);

    always_comb begin
        req_grant_o = '0;
        if (push_xfer) begin
            req_grant_o[winner] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. A stall (valid without FIFO grant) matches no branch
    // that changes state, so everything holds.
    // ------------------------------------------------------------------
    assign beat_inc = beat_cnt_q + BEAT_ONE;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (push_xfer) begin
                    if (MAX_BURST == 1) begin
                        // Single-beat ownership: stay idle, move past winner.
                        rr_ptr_d = IDX_W'(mod_inc(32'(winner), NUM_REQ));
                    end else begin
                        state_d    = ARB_LOCKED;
                        owner_d    = winner;
                        beat_cnt_d = BEAT_ONE;
                    end
                end
            end

            ARB_LOCKED: begin
                if (!req_valid_i[owner_q]) begin
                    // Owner withdrew: release without serving anyone else
                    // this cycle; next search starts after the owner.
                    state_d    = ARB_IDLE;
                    rr_ptr_d   = IDX_W'(mod_inc(32'(owner_q), NUM_REQ));
                    beat_cnt_d = '0;
                end else if (push_xfer) begin
                    if (beat_inc == BEAT_LAST) begin
                        state_d    = ARB_IDLE;
                        rr_ptr_d   = IDX_W'(mod_inc(32'(owner_q), NUM_REQ));
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_inc;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule : fifo_push_arbiter

// File: tb/tb_fifo_push_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_push_arbiter
// Two arbiter instances share the same requester/FIFO stimulus: index 0 uses
// MAX_BURST=4, index 1 uses MAX_BURST=1. A behavioural model tracks owner,
// remaining burst length and the round-robin start for each instance.
// ----------------------------------------------------------------------------
module tb_fifo_push_arbiter;

    localparam int DW = 32;
    localparam int PW = DW + 1;
    localparam int NR = 4;

    typedef logic [1+NR+2+1+PW-1:0] obs_t;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*PW-1:0]  req_data;
    logic              push_grant;

    logic [NR-1:0]     grant_w  [2];
    logic              pvalid_w [2];
    logic [PW-1:0]     pdata_w  [2];
    logic [1:0]        owner_w  [2];
    logic              locked_w [2];

    int tests_run    = 0;
    int tests_failed = 0;

    // model state per instance
    int m_locked [2];
    int m_owner  [2];
    int m_beats  [2];
    int m_rr     [2];
    int mb       [2];

    fifo_push_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4)) dut4 (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid),
        .req_data_i        (req_data),
        .req_grant_o       (grant_w[0]),
        .fifo_push_valid_o (pvalid_w[0]),
        .fifo_push_data_o  (pdata_w[0]),
        .fifo_push_grant_i (push_grant),
        .owner_o           (owner_w[0]),
        .locked_o          (locked_w[0])
    );

    fifo_push_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(1)) dut1 (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid),
        .req_data_i        (req_data),
        .req_grant_o       (grant_w[1]),
        .fifo_push_valid_o (pvalid_w[1]),
        .fifo_push_data_o  (pdata_w[1]),
        .fifo_push_grant_i (push_grant),
        .owner_o           (owner_w[1]),
        .locked_o          (locked_w[1])
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [PW-1:0] slice(input int w);
        return req_data[w*PW +: PW];
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_locked[k] = 0;
            m_owner[k]  = 0;
            m_beats[k]  = 0;
            m_rr[k]     = 0;
        end
    endfunction

    function automatic int model_winner(input int k);
        if (m_locked[k] != 0) return m_owner[k];
        for (int i = 0; i < NR; i++) begin
            if (req_valid[(m_rr[k] + i) % NR]) return (m_rr[k] + i) % NR;
        end
        return m_rr[k];
    endfunction

    function automatic obs_t expect_obs(input int k);
        int         w;
        logic       v;
        logic [3:0] g;
        if (!rst_n) return {1'b0, 4'b0000, 2'b00, 1'b0, slice(0)};
        w = model_winner(k);
        v = req_valid[w];
        g = (v && push_grant) ? 4'(1 << w) : 4'b0000;
        return {v, g, 2'(w), (m_locked[k] != 0), slice(w)};
    endfunction

    function automatic obs_t act_obs(input int k);
        return {pvalid_w[k], grant_w[k], owner_w[k], locked_w[k], pdata_w[k]};
    endfunction

    // Advance the model across one rising edge using the current inputs.
    function automatic void model_edge(input int k);
        int w;
        bit xfer;
        if (!rst_n) begin
            m_locked[k] = 0; m_owner[k] = 0; m_beats[k] = 0; m_rr[k] = 0;
            return;
        end
        w    = model_winner(k);
        xfer = req_valid[w] && push_grant;
        if (m_locked[k] == 0) begin
            if (xfer) begin
                if (mb[k] == 1) begin
                    m_rr[k] = (w + 1) % NR;
                end else begin
                    m_locked[k] = 1;
                    m_owner[k]  = w;
                    m_beats[k]  = 1;
                end
            end
        end else if (!req_valid[m_owner[k]]) begin
            m_locked[k] = 0;
            m_rr[k]     = (m_owner[k] + 1) % NR;
            m_beats[k]  = 0;
        end else if (xfer) begin
            m_beats[k] = m_beats[k] + 1;
            if (m_beats[k] == mb[k]) begin
                m_locked[k] = 0;
                m_rr[k]     = (m_owner[k] + 1) % NR;
                m_beats[k]  = 0;
            end
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic rand_data();
        for (int i = 0; i < NR; i++) begin
            req_data[i*PW +: PW] = {1'($urandom_range(0, 1)), $urandom};
        end
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        push_grant = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        obs_t e, a;
        rst_n = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            req_valid  = 4'($urandom_range(1, 15));
            push_grant = 1'b1;
            rand_data();
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                e = expect_obs(k); a = act_obs(k);
                tests_run++;
                if (a !== e) begin
                    tests_failed++;
                    $display("FAIL reset_hold dut%0d cyc%0d: got %h want %h", k, c, a, e);
                end
            end
            tick();
        end
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        tests_run++;
        if ({pvalid_w[0], grant_w[0], owner_w[0]} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got v=%b g=%b o=%0d want 0/0000/0",
                     pvalid_w[0], grant_w[0], owner_w[0]);
        end
        tick();
    endtask

    task automatic test_round_robin();
        obs_t e, a;
        int   exp_idx;
        do_reset();
        req_valid  = 4'b1111;
        push_grant = 1'b1;
        for (int c = 0; c < 17; c++) begin
            rand_data();
            @(negedge clk);
            exp_idx = (c / 4) % NR;
            tests_run++;
            if (grant_w[0] !== 4'(1 << exp_idx)) begin
                tests_failed++;
                $display("FAIL rr_order cyc%0d: got %b want %b", c, grant_w[0], 4'(1 << exp_idx));
            end
            for (int k = 0; k < 2; k++) begin
                e = expect_obs(k); a = act_obs(k);
                tests_run++;
                if (a !== e) begin
                    tests_failed++;
                    $display("FAIL rr_model dut%0d cyc%0d: got %h want %h", k, c, a, e);
                end
            end
            tick();
        end
    endtask

    task automatic test_owner_drop();
        obs_t e, a;
        do_reset();
        push_grant = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_valid = (c < 2) ? 4'b0100 : 4'b1011;
            rand_data();
            @(negedge clk);
            if (c == 2) begin
                tests_run++;
                if ({pvalid_w[0], grant_w[0], locked_w[0]} !== 6'b000001) begin
                    tests_failed++;
                    $display("FAIL drop_noserve: got v=%b g=%b l=%b want 0/0000/1",
                             pvalid_w[0], grant_w[0], locked_w[0]);
                end
            end
            if (c == 3) begin
                tests_run++;
                if (grant_w[0] !== 4'b1000) begin
                    tests_failed++;
                    $display("FAIL drop_next: got %b want 1000", grant_w[0]);
                end
            end
            for (int k = 0; k < 2; k++) begin
                e = expect_obs(k); a = act_obs(k);
                tests_run++;
                if (a !== e) begin
                    tests_failed++;
                    $display("FAIL drop_model dut%0d cyc%0d: got %h want %h", k, c, a, e);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        obs_t          e, a;
        logic [PW-1:0] held;
        do_reset();
        req_valid  = 4'b0010;
        push_grant = 1'b1;
        rand_data();
        tick();
        held       = slice(1);
        req_valid  = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            push_grant = (c >= 5);
            @(negedge clk);
            if (c < 5) begin
                tests_run++;
                if ({grant_w[0], owner_w[0], locked_w[0], pdata_w[0]} !== {4'b0000, 2'd1, 1'b1, held}) begin
                    tests_failed++;
                    $display("FAIL stall_hold cyc%0d: got g=%b o=%0d l=%b d=%h want 0000/1/1/%h",
                             c, grant_w[0], owner_w[0], locked_w[0], pdata_w[0], held);
                end
            end
            if (c == 8) begin
                tests_run++;
                if (owner_w[0] !== 2'd2) begin
                    tests_failed++;
                    $display("FAIL stall_resume: got owner %0d want 2", owner_w[0]);
                end
            end
            for (int k = 0; k < 2; k++) begin
                e = expect_obs(k); a = act_obs(k);
                tests_run++;
                if (a !== e) begin
                    tests_failed++;
                    $display("FAIL stall_model dut%0d cyc%0d: got %h want %h", k, c, a, e);
                end
            end
            tick();
        end
    endtask

    task automatic test_single_beat();
        obs_t e, a;
        logic [3:0] exp_g;
        do_reset();
        req_valid  = 4'b0101;
        push_grant = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rand_data();
            @(negedge clk);
            exp_g = (c % 2 == 0) ? 4'b0001 : 4'b0100;
            tests_run++;
            if (grant_w[1] !== exp_g) begin
                tests_failed++;
                $display("FAIL mb1_alt cyc%0d: got %b want %b", c, grant_w[1], exp_g);
            end
            for (int k = 0; k < 2; k++) begin
                e = expect_obs(k); a = act_obs(k);
                tests_run++;
                if (a !== e) begin
                    tests_failed++;
                    $display("FAIL mb1_model dut%0d cyc%0d: got %h want %h", k, c, a, e);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid  = 4'b1000;
        push_grant = 1'b1;
        rand_data();
        tick();
        tick();
        // dut4 now owns requester 3 with two beats done
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({pvalid_w[0], grant_w[0], owner_w[0], locked_w[0], pdata_w[0]} !== {8'b0, slice(0)}) begin
            tests_failed++;
            $display("FAIL mid_reset_quiet: got v=%b g=%b o=%0d l=%b d=%h",
                     pvalid_w[0], grant_w[0], owner_w[0], locked_w[0], pdata_w[0]);
        end
        req_valid = 4'b1111;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({grant_w[0], owner_w[0]} !== {4'b0001, 2'd0}) begin
            tests_failed++;
            $display("FAIL mid_reset_restart: got g=%b o=%0d want 0001/0", grant_w[0], owner_w[0]);
        end
        tick();
    endtask

    task automatic test_random();
        obs_t e, a;
        for (int c = 0; c < 400; c++) begin
            req_valid  = 4'($urandom_range(0, 15));
            push_grant = ($urandom_range(0, 3) != 0);
            rand_data();
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                e = expect_obs(k); a = act_obs(k);
                tests_run++;
                if (a !== e) begin
                    tests_failed++;
                    $display("FAIL random dut%0d cyc%0d: got %h want %h", k, c, a, e);
                end
            end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        mb[0]      = 4;
        mb[1]      = 1;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        push_grant = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_round_robin();
        test_owner_drop();
        test_stall();
        test_single_beat();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_fifo_push_arbiter
